bcd_calc_n: RTL and testbench

BCD_CALC_N -- requirements
Module: bcd_calc_n

---
 rtl/bcd_calc_pkg.sv | 20 ++
 rtl/bcd_digit_alu.sv | 44 ++++
 rtl/bcd_calc_n.sv | 190 +++++++++++++++++++
 tb/tb_bcd_calc_n.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_calc_pkg.sv
// Shared definitions for the BCD calculator: digit width, digit maximum,
// FSM state encoding and a wrap-around digit increment helper.
package bcd_calc_pkg;

   localparam int            BCD_W   = 4;
   localparam logic [3:0]    BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTRY = 2'd1,
      ST_CALC  = 2'd2,
      ST_SHOW  = 2'd3
   } state_t;

   // 0..8 -> +1, 9 -> 0; never carries into the neighbouring digit
   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
      return (d >= BCD_MAX) ? '0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/bcd_digit_alu.sv
// Single-digit BCD add/subtract with carry/borrow; time-shared by the
// calculator across all digit positions, least significant first.
module bcd_digit_alu
   import bcd_calc_pkg::*;
(
   input  logic [BCD_W-1:0] i_a,
   input  logic [BCD_W-1:0] i_b,
   input  logic             i_cin,
   input  logic             i_sub,
   output logic [BCD_W-1:0] o_dig,
   output logic             o_cout
);

   localparam logic [BCD_W:0] TEN = 5'd10;

   logic [BCD_W:0] w_raw;
   logic [BCD_W:0] w_adj;

   always_comb begin
      w_raw  = '0;
      w_adj  = '0;
      o_cout = 1'b0;
      if (i_sub) begin
         // wraps negative below zero; bit BCD_W flags the borrow
         w_raw = {1'b0, i_a} - {1'b0, i_b} - {{BCD_W{1'b0}}, i_cin};
         if (w_raw[BCD_W]) begin
            w_adj  = w_raw + TEN;
            o_cout = 1'b1;
         end else begin
            w_adj  = w_raw;
         end
      end else begin
         w_raw = {1'b0, i_a} + {1'b0, i_b} + {{BCD_W{1'b0}}, i_cin};
         if (w_raw > {1'b0, BCD_MAX}) begin
            w_adj  = w_raw - TEN;
            o_cout = 1'b1;
         end else begin
            w_adj  = w_raw;
         end
      end
      o_dig = w_adj[BCD_W-1:0];
   end

endmodule

// File: rtl/bcd_calc_n.sv
// NDIG-digit BCD add/subtract calculator driven by debounced-free async
// buttons: operands entered digit by digit, result computed serially.
//
// state  | meaning
// IDLE   | waiting for first cal press after reset
// ENTRY  | key presses increment operand digits
// CALC   | one digit per clock through the shared digit ALU, LSD first
// SHOW   | result and sign stable; cal returns to ENTRY keeping operands
module bcd_calc_n
   import bcd_calc_pkg::*;
#(
   parameter int NDIG        = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cal,
   input  logic                        op_sel,
   input  logic [2*NDIG-1:0]           key_inc,
   output logic [BCD_W*NDIG-1:0]       dig_a,
   output logic [BCD_W*NDIG-1:0]       dig_b,
   output logic [BCD_W*(NDIG+1)-1:0]   res,
   output logic                        neg,
   output logic [1:0]                  state,
   output logic                        busy,
   output logic                        done
);

   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int KW    = 2 * NDIG;

   logic [SYNC_STAGES-1:0]         r_cal_sync;
   logic [SYNC_STAGES-1:0]         r_op_sync;
   logic [SYNC_STAGES-1:0]         r_vld;
   logic [KW-1:0]                  r_key_sync [SYNC_STAGES];
   logic                           r_cal_prev;
   logic                           r_cal_armed;
   logic [KW-1:0]                  r_key_prev;

   state_t                         r_state;
   logic [BCD_W*NDIG-1:0]          r_a;
   logic [BCD_W*NDIG-1:0]          r_b;
   logic [BCD_W*(NDIG+1)-1:0]      r_res;
   logic                           r_neg;
   logic                           r_done;
   logic                           r_op;
   logic                           r_swap;
   logic [CNT_W-1:0]               r_cnt;
   logic                           r_carry;

   logic                           w_cal_s;
   logic                           w_op_s;
   logic [KW-1:0]                  w_key_s;
   logic                           w_cal_evt;
   logic [KW-1:0]                  w_key_evt;
   logic [BCD_W-1:0]               w_x;
   logic [BCD_W-1:0]               w_y;
   logic [BCD_W-1:0]               w_sum;
   logic                           w_cout;
   logic                           w_last;

   assign w_cal_s = r_cal_sync[SYNC_STAGES-1];
   assign w_op_s  = r_op_sync[SYNC_STAGES-1];
   assign w_key_s = r_key_sync[SYNC_STAGES-1];

   // cal must be seen low after reset before its rising edge counts
   assign w_cal_evt = w_cal_s & ~r_cal_prev & r_cal_armed;
   assign w_key_evt = w_key_s & ~r_key_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cal_sync  <= '0;
         r_op_sync   <= '0;
         r_vld       <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) r_key_sync[i] <= '0;
         r_cal_prev  <= 1'b0;
         r_key_prev  <= '0;
         r_cal_armed <= 1'b0;
      end else begin
         r_cal_sync    <= {r_cal_sync[SYNC_STAGES-2:0], cal};
         r_op_sync     <= {r_op_sync[SYNC_STAGES-2:0], op_sel};
         r_vld         <= {r_vld[SYNC_STAGES-2:0], 1'b1};
         r_key_sync[0] <= key_inc;
         for (int i = 1; i < SYNC_STAGES; i++) r_key_sync[i] <= r_key_sync[i-1];
         r_cal_prev    <= w_cal_s;
         r_key_prev    <= w_key_s;
         if (r_vld[SYNC_STAGES-1] && !w_cal_s) r_cal_armed <= 1'b1;
      end
   end

   // larger magnitude goes in as the minuend so the result is |A-B|
   always_comb begin
      w_x = '0;
      w_y = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (r_cnt == CNT_W'(i)) begin
            w_x = r_swap ? r_b[BCD_W*i +: BCD_W] : r_a[BCD_W*i +: BCD_W];
            w_y = r_swap ? r_a[BCD_W*i +: BCD_W] : r_b[BCD_W*i +: BCD_W];
         end
      end
   end

   assign w_last = (r_cnt == CNT_W'(NDIG - 1));

   bcd_digit_alu u_alu (
      .i_a    (w_x),
      .i_b    (w_y),
      .i_cin  (r_carry),
      .i_sub  (r_op),
      .o_dig  (w_sum),
      .o_cout (w_cout)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_neg   <= 1'b0;
         r_done  <= 1'b0;
         r_op    <= 1'b0;
         r_swap  <= 1'b0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_cal_evt) begin
                  r_state <= ST_ENTRY;
                  r_a     <= '0;
                  r_b     <= '0;
                  r_res   <= '0;
                  r_neg   <= 1'b0;
               end
            end
            ST_ENTRY: begin
               if (w_cal_evt) begin
                  r_state <= ST_CALC;
                  r_op    <= w_op_s;
                  // packed BCD orders the same as its decimal value
                  r_swap  <= w_op_s && (r_a < r_b);
                  r_cnt   <= '0;
                  r_carry <= 1'b0;
               end else begin
                  for (int i = 0; i < NDIG; i++) begin
                     if (w_key_evt[i])
                        r_b[BCD_W*i +: BCD_W] <= bcd_inc(r_b[BCD_W*i +: BCD_W]);
                     if (w_key_evt[NDIG+i])
                        r_a[BCD_W*i +: BCD_W] <= bcd_inc(r_a[BCD_W*i +: BCD_W]);
                  end
               end
            end
            ST_CALC: begin
               for (int i = 0; i < NDIG; i++) begin
                  if (r_cnt == CNT_W'(i)) r_res[BCD_W*i +: BCD_W] <= w_sum;
               end
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_res[BCD_W*NDIG +: BCD_W] <= (!r_op && w_cout) ? 4'd1 : 4'd0;
                  r_state <= ST_SHOW;
                  r_neg   <= r_swap;
                  r_done  <= 1'b1;
                  r_cnt   <= '0;
                  r_carry <= 1'b0;
               end
            end
            ST_SHOW: begin
               if (w_cal_evt) begin
                  r_state <= ST_ENTRY;
                  r_res   <= '0;
                  r_neg   <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign dig_a = r_a;
   assign dig_b = r_b;
   assign res   = r_res;
   assign neg   = r_neg;
   assign state = r_state;
   assign busy  = (r_state == ST_CALC);
   assign done  = r_done;

endmodule

// File: tb/tb_bcd_calc_n.sv
// Directed bench for bcd_calc_n at NDIG=2 and NDIG=4; expected results come
// from a decimal model and are queued until the DUT signals done.
module tb_bcd_calc_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        cal, op_sel;
   logic [3:0]  key_inc;
   logic [7:0]  dig_a, dig_b;
   logic [11:0] res;
   logic        neg, busy, done;
   logic [1:0]  state;

   logic        cal4, op4;
   logic [7:0]  key4;
   logic [15:0] dig_a4, dig_b4;
   logic [19:0] res4;
   logic        neg4, busy4, done4;
   logic [1:0]  state4;

   bcd_calc_n #(.NDIG(2), .SYNC_STAGES(2)) dut2 (
      .clk(clk), .rst(rst), .cal(cal), .op_sel(op_sel), .key_inc(key_inc),
      .dig_a(dig_a), .dig_b(dig_b), .res(res), .neg(neg), .state(state),
      .busy(busy), .done(done));

   bcd_calc_n #(.NDIG(4), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .rst(rst), .cal(cal4), .op_sel(op4), .key_inc(key4),
      .dig_a(dig_a4), .dig_b(dig_b4), .res(res4), .neg(neg4), .state(state4),
      .busy(busy4), .done(done4));

   typedef struct {
      logic [31:0] res;
      logic        neg;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   mA = 0, mB = 0;

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic press_cal();
      cal = 1'b1; tick(3);
      cal = 1'b0; tick(3);
   endtask

   task automatic press_keys(input logic [3:0] vec);
      key_inc = vec; tick(3);
      key_inc = '0; tick(3);
   endtask

   task automatic set_ops(input int a, input int b);
      int da[2];
      int db[2];
      int p;
      logic [3:0] vec;
      for (int d = 0; d < 2; d++) begin
         p = (d == 0) ? 1 : 10;
         da[d] = ((a / p) % 10 - (mA / p) % 10 + 10) % 10;
         db[d] = ((b / p) % 10 - (mB / p) % 10 + 10) % 10;
      end
      for (int k = 0; k < 9; k++) begin
         vec = '0;
         for (int d = 0; d < 2; d++) begin
            if (k < db[d]) vec[d]     = 1'b1;
            if (k < da[d]) vec[2 + d] = 1'b1;
         end
         if (vec != 0) press_keys(vec);
      end
      mA = a;
      mB = b;
      check("dig_a", dig_a, to_bcd(mA));
      check("dig_b", dig_b, to_bcd(mB));
   endtask

   task automatic run_calc(input logic sub, input logic [3:0] kvec);
      exp_t e;
      int   busy_cnt;
      logic seen;
      if (sub) begin
         e.res = to_bcd((mA >= mB) ? mA - mB : mB - mA);
         e.neg = (mA < mB);
      end else begin
         e.res = to_bcd(mA + mB);
         e.neg = 1'b0;
      end
      q.push_back(e);
      op_sel   = sub;
      cal      = 1'b1;
      key_inc  = kvec;
      busy_cnt = 0;
      seen     = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick(1);
         if (i == 2) begin
            cal     = 1'b0;
            key_inc = '0;
         end
         if (busy) busy_cnt++;
         if (done) seen = 1'b1;
      end
      check("done_seen", seen, 1);
      if (q.size() > 0) begin
         e = q.pop_front();
         check("res", res, e.res);
         check("neg", neg, e.neg);
      end
      check("busy_cycles", busy_cnt, 2);
      tick(1);
      check("done_width", done, 0);
      check("show_state", state, 3);
      cal = 1'b0;
      tick(3);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   busy_cnt;
      logic seen;

      rst = 1'b0; cal = 1'b0; op_sel = 1'b0; key_inc = '0;
      cal4 = 1'b0; op4 = 1'b0; key4 = '0;
      tick(3);
      check("rst_state", state, 0);
      check("rst_res", res, 0);
      check("rst_dig_a", dig_a, 0);
      check("rst_busy_done", {busy, done, neg}, 0);
      rst = 1'b1;
      tick(5);

      press_cal();
      check("entry", state, 1);

      set_ops(47, 85);
      run_calc(1'b0, 4'b0000);

      press_cal();
      check("reentry", state, 1);
      check("reentry_res", res, 0);
      check("keep_a", dig_a, to_bcd(mA));

      set_ops(23, 58);
      run_calc(1'b1, 4'b0000);
      press_cal();
      set_ops(58, 58);
      run_calc(1'b1, 4'b0000);
      press_cal();
      set_ops(99, 99);
      run_calc(1'b0, 4'b0000);

      // single-digit wrap without carry, then back round to the start
      press_cal();
      press_keys(4'b0001);
      mB = (mB / 10) * 10 + ((mB % 10) + 1) % 10;
      check("wrap_one", dig_b, to_bcd(mB));
      for (int k = 0; k < 9; k++) press_keys(4'b0001);
      mB = (mB / 10) * 10 + ((mB % 10) + 9) % 10;
      check("wrap_ten", dig_b, to_bcd(mB));

      // key together with cal: cal wins, operand untouched
      run_calc(1'b0, 4'b0100);
      check("key_cal_a", dig_a, to_bcd(mA));

      press_keys(4'b1111);
      check("show_key_a", dig_a, to_bcd(mA));
      check("show_key_b", dig_b, to_bcd(mB));

      // reset in the second CALC cycle, cal held across release
      press_cal();
      check("pre_rst_entry", state, 1);
      op_sel = 1'b0;
      cal    = 1'b1;
      for (int i = 0; i < 10 && !busy; i++) tick(1);
      check("reached_calc", busy, 1);
      tick(1);
      rst = 1'b0;
      #1;
      check("mid_rst_state", state, 0);
      check("mid_rst_res", res, 0);
      check("mid_rst_ops", {dig_a, dig_b}, 0);
      check("mid_rst_flags", {neg, busy, done}, 0);
      tick(2);
      rst = 1'b1;
      tick(8);
      check("held_cal_no_evt", state, 0);
      cal = 1'b0;
      tick(4);
      press_cal();
      mA = 0; mB = 0;
      check("post_rst_entry", state, 1);
      check("post_rst_a", dig_a, 0);

      // NDIG=4: 9999 + 0001
      cal4 = 1'b1; tick(3); cal4 = 1'b0; tick(3);
      check("n4_entry", state4, 1);
      for (int k = 0; k < 9; k++) begin
         key4 = (k == 0) ? 8'hF1 : 8'hF0;
         tick(3);
         key4 = '0;
         tick(3);
      end
      check("n4_dig_a", dig_a4, to_bcd(9999));
      check("n4_dig_b", dig_b4, to_bcd(1));
      e.res = to_bcd(9999 + 1);
      e.neg = 1'b0;
      q.push_back(e);
      cal4 = 1'b1;
      busy_cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick(1);
         if (i == 2) cal4 = 1'b0;
         if (busy4) busy_cnt++;
         if (done4) seen = 1'b1;
      end
      check("n4_done_seen", seen, 1);
      if (q.size() > 0) begin
         e = q.pop_front();
         check("n4_res", res4, e.res);
         check("n4_neg", neg4, e.neg);
      end
      check("n4_busy_cycles", busy_cnt, 4);
      tick(1);
      check("n4_done_width", done4, 0);
      check("queue_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
